// File: rtl/divide_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with a divide-by-zero shortcut.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// S_IDLE   | waiting for start; operands latched on accept
// S_DIVIDE | one restoring shift/subtract step per cycle, WIDTH steps
// S_DONE   | one-cycle done pulse; result registers already hold the answer
module divide_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient_out,
   output logic [WIDTH-1:0] remainder_out,
   output logic             div_by_zero
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DIVIDE = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remo_q, remo_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   shifted;
   logic             ge;
   logic [WIDTH:0]   step_rem;
   logic [WIDTH-1:0] step_q;

   always_comb begin
      shifted  = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
      ge       = (shifted >= {1'b0, divisor_q});
      step_rem = ge ? (shifted - {1'b0, divisor_q}) : shifted;
      step_q   = {q_q[WIDTH-2:0], ge};
   end

   // Result registers are loaded on the edge that enters S_DONE so they are
   // already valid while done is high.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      q_d       = q_q;
      divisor_d = divisor_q;
      count_d   = count_q;
      quot_d    = quot_q;
      remo_d    = remo_q;
      dbz_d     = dbz_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               divisor_d = divisor_in;
               q_d       = dividend_in;
               rem_d     = '0;
               count_d   = '0;
               if (divisor_in == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  quot_d  = '1;
                  remo_d  = dividend_in;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = S_DIVIDE;
               end
            end
         end
         S_DIVIDE: begin
            rem_d   = step_rem;
            q_d     = step_q;
            count_d = count_q + 1'b1;
            if (count_q == LAST_STEP) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               quot_d  = step_q;
               remo_d  = step_rem[WIDTH-1:0];
               dbz_d   = 1'b0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         rem_q     <= '0;
         q_q       <= '0;
         divisor_q <= '0;
         count_q   <= '0;
         quot_q    <= '0;
         remo_q    <= '0;
         dbz_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         q_q       <= q_d;
         divisor_q <= divisor_d;
         count_q   <= count_d;
         quot_q    <= quot_d;
         remo_q    <= remo_d;
         dbz_q     <= dbz_d;
         done_q    <= done_d;
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign done          = done_q;
   assign quotient_out  = quot_q;
   assign remainder_out = remo_q;
   assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_divide_seq.sv
// Scoreboard bench for divide_seq: expected results and their done cycle are
// queued at each accepted start and compared when done appears.
module tb_divide_seq;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] dividend_in;
   logic [WIDTH-1:0] divisor_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient_out;
   logic [WIDTH-1:0] remainder_out;
   logic             div_by_zero;

   divide_seq #(.WIDTH(WIDTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .dividend_in   (dividend_in),
      .divisor_in    (divisor_in),
      .busy          (busy),
      .done          (done),
      .quotient_out  (quotient_out),
      .remainder_out (remainder_out),
      .div_by_zero   (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             dbz;
      int               cyc;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // done must appear exactly in the cycle the head entry predicts
   always @(negedge clk) begin
      if (mon_en) begin
         automatic bit   exp_done = (sb.size() > 0) && (sb[0].cyc == cyc);
         automatic exp_t e;
         chk("done", {63'b0, done}, {63'b0, exp_done});
         if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (done) begin
               chk("quotient", quotient_out, e.q);
               chk("remainder", remainder_out, e.r);
               chk("div_by_zero", div_by_zero, e.dbz);
               chk("busy_at_done", busy, 1);
               if (e.b != 0) begin
                  chk("invariant", 64'(quotient_out) * 64'(e.b) + 64'(remainder_out), 64'(e.a));
                  chk("rem_lt_div", {63'b0, remainder_out < e.b}, 64'd1);
               end
            end
         end
      end
   end

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int   n = 0;
      exp_t e;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) chk("idle_wait", busy, 0);
      dividend_in = a;
      divisor_in  = b;
      start       = 1'b1;
      e.a = a;
      e.b = b;
      if (b == 0) begin
         e.q = '1; e.r = a; e.dbz = 1'b1; e.cyc = cyc + 1;
      end else begin
         e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.cyc = cyc + WIDTH + 1;
      end
      sb.push_back(e);
      @(negedge clk);
      start       = 1'b0;
      dividend_in = $urandom;
      divisor_in  = $urandom;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_busy", busy, 0);
   endtask

   initial begin
      int nb;
      int n;
      logic [WIDTH-1:0] a, b;
      reset = 1'b1; start = 1'b0; dividend_in = '0; divisor_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_q", quotient_out, 0);
      chk("rst_r", remainder_out, 0);
      chk("rst_dbz", div_by_zero, 0);
      reset  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // 100/7 with busy length
      issue(100, 7);
      nb = 0;
      while (busy && nb < 100) begin
         nb++;
         @(negedge clk);
      end
      chk("busy_len", nb, 33);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("hold_q", quotient_out, 14);
      chk("hold_r", remainder_out, 2);

      // extremes, back to back
      issue(32'hFFFF_FFFF, 1);
      issue(5, 9);
      issue(0, 3);
      wait_idle();

      // divide by zero, then cleared by a normal divide
      issue(1234, 0);
      wait_idle();
      chk("dbz_hold", div_by_zero, 1);
      issue(10, 3);
      wait_idle();
      chk("dbz_clear", div_by_zero, 0);

      // reset mid-operation aborts without done
      issue(1000, 3);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_q", quotient_out, 0);
      chk("abort_r", remainder_out, 0);
      repeat (40) @(negedge clk);
      issue(9, 2);
      wait_idle();

      // start while busy and in the DONE cycle is ignored
      issue(50, 5);
      repeat (3) @(negedge clk);
      dividend_in = 7; divisor_in = 0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      dividend_in = 8; divisor_in = 0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      chk("ignore_q", quotient_out, 10);
      chk("ignore_r", remainder_out, 0);
      chk("ignore_dbz", div_by_zero, 0);

      // random operands, back to back
      for (int i = 0; i < 2000; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 6))
            0: a = 0;
            1: b = 0;
            2: b = 1;
            3: a = '1;
            4: begin a = $urandom_range(0, 1000); b = a + $urandom_range(1, 1000); end
            5: b = $urandom_range(1, 300);
            default: ;
         endcase
         issue(a, b);
      end
      wait_idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
